// File: rtl/fetch_unit.sv
// Fetch stage: sequences the PC into a 1-cycle-latency instruction memory and pairs each
// returned word with its PC. Define FETCH_HALT_EN to stop fetching on the HALT_OP opcode.
module fetch_unit #(
   parameter int                ADDR_W   = 4,
   parameter int                INSTR_W  = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OP  = 4'hF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [ADDR_W-1:0]  read_address,
   input  logic [INSTR_W-1:0] instruction_in,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               instr_valid,
   output logic               halted
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

`ifdef FETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   state_t             state;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pc_q;
   logic               valid_q;
   logic               halt_op_seen;

   assign halt_op_seen = (instruction_in[INSTR_W-1 -: 4] == HALT_OP);

   // A stall re-reads pc_q so the memory keeps returning the held instruction.
   always_comb begin
      read_address = pc;
      if (state == RUN) begin
         if (branch_taken)
            read_address = branch_target;
         else if (stall)
            read_address = pc_q;
      end
   end

   assign instr_valid = valid_q;
   assign instr_out   = valid_q ? instruction_in : '0;
   assign pc_out      = pc_q;

`ifdef FETCH_HALT_EN
   assign halted = (state == HALT);
`else
   assign halted = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc      <= RESET_PC;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         state   <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  valid_q <= 1'b1;
                  pc_q    <= pc;
                  pc      <= pc + ADDR_W'(1);
               end
            end
            RUN: begin
               if (branch_taken) begin
                  pc_q    <= branch_target;
                  pc      <= branch_target + ADDR_W'(1);
                  valid_q <= 1'b1;
               end else if (!stall) begin
                  if (HALT_EN && valid_q && halt_op_seen) begin
                     state   <= HALT;
                     valid_q <= 1'b0;
                  end else begin
                     pc_q <= pc;
                     pc   <= pc + ADDR_W'(1);
                  end
               end
            end
            default: begin
               // HALT: everything frozen until reset
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle registered memory model (mem[i] = 12'h100 + i).
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        stall;
   logic        branch_taken;
   logic [3:0]  branch_target;
   logic [3:0]  read_address;
   logic [11:0] instruction_in;
   logic [11:0] instr_out;
   logic [3:0]  pc_out;
   logic        instr_valid;
   logic        halted;

   logic [11:0] mem [16];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .read_address(read_address), .instruction_in(instruction_in),
      .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid), .halted(halted)
   );

   always @(posedge clk) instruction_in <= mem[read_address];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 4'd0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
      checks++; if (instr_out !== 12'h000) begin errors++; $display("FAIL reset_instr got=%0h exp=0", instr_out); end
      checks++; if (pc_out !== 4'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", pc_out); end
      checks++; if (read_address !== 4'd0) begin errors++; $display("FAIL reset_raddr got=%0d exp=0", read_address); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%0b exp=0", halted); end
      step();
      reset_n = 1'b1;
      branch_taken = 1'b1; branch_target = 4'd7; stall = 1'b1;
      #1;
      checks++; if (read_address !== 4'd0) begin errors++; $display("FAIL idle_raddr got=%0d exp=0", read_address); end
      step();
      step();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%0b exp=0", instr_valid); end
      checks++; if (pc_out !== 4'd0) begin errors++; $display("FAIL idle_pc got=%0d exp=0", pc_out); end
      branch_taken = 1'b0; stall = 1'b0;
   endtask

   task automatic test_start();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         if (i > 0) step();
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL start_valid[%0d] got=%0b exp=1", i, instr_valid); end
         checks++; if (pc_out !== 4'(i)) begin errors++; $display("FAIL start_pc[%0d] got=%0d exp=%0d", i, pc_out, i); end
         checks++; if (instr_out !== 12'(12'h100 + i)) begin errors++; $display("FAIL start_instr[%0d] got=%0h exp=%0h", i, instr_out, 12'h100 + i); end
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) step();
         #1;
         checks++; if (read_address !== 4'd5) begin errors++; $display("FAIL stall_raddr[%0d] got=%0d exp=5", c, read_address); end
         checks++; if (pc_out !== 4'd5) begin errors++; $display("FAIL stall_pc[%0d] got=%0d exp=5", c, pc_out); end
         checks++; if (instr_out !== 12'h105) begin errors++; $display("FAIL stall_instr[%0d] got=%0h exp=105", c, instr_out); end
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%0b exp=1", c, instr_valid); end
      end
      stall = 1'b0;
      step();
      checks++; if (pc_out !== 4'd6) begin errors++; $display("FAIL unstall_pc got=%0d exp=6", pc_out); end
      checks++; if (instr_out !== 12'h106) begin errors++; $display("FAIL unstall_instr got=%0h exp=106", instr_out); end
   endtask

   task automatic test_branch(input logic with_stall);
      branch_taken = 1'b1; branch_target = 4'd3;
      step();
      checks++; if (pc_out !== 4'd3) begin errors++; $display("FAIL br_setup_pc got=%0d exp=3", pc_out); end
      branch_target = 4'd12; stall = with_stall;
      #1;
      checks++; if (read_address !== 4'd12) begin errors++; $display("FAIL br_raddr(stall=%0b) got=%0d exp=12", with_stall, read_address); end
      step();
      branch_taken = 1'b0; stall = 1'b0;
      checks++; if (pc_out !== 4'd12) begin errors++; $display("FAIL br_pc(stall=%0b) got=%0d exp=12", with_stall, pc_out); end
      checks++; if (instr_out !== 12'h10C) begin errors++; $display("FAIL br_instr(stall=%0b) got=%0h exp=10c", with_stall, instr_out); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL br_valid(stall=%0b) got=%0b exp=1", with_stall, instr_valid); end
      step();
      checks++; if (pc_out !== 4'd13) begin errors++; $display("FAIL br_next_pc(stall=%0b) got=%0d exp=13", with_stall, pc_out); end
      checks++; if (instr_out !== 12'h10D) begin errors++; $display("FAIL br_next_instr(stall=%0b) got=%0h exp=10d", with_stall, instr_out); end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_pc [4];
      exp_pc[0] = 4'd14; exp_pc[1] = 4'd15; exp_pc[2] = 4'd0; exp_pc[3] = 4'd1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (pc_out !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d] got=%0d exp=%0d", i, pc_out, exp_pc[i]); end
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d] got=%0b exp=1", i, instr_valid); end
         checks++; if (instr_out !== (12'h100 | 12'(exp_pc[i]))) begin errors++; $display("FAIL wrap_instr[%0d] got=%0h exp=%0h", i, instr_out, 12'h100 | 12'(exp_pc[i])); end
         if (i == 1) begin
            checks++; if (read_address !== 4'd0) begin errors++; $display("FAIL wrap_raddr got=%0d exp=0", read_address); end
         end
      end
   endtask

   task automatic test_reset_mid_run();
      for (int i = 0; i < 8; i++) step();
      checks++; if (pc_out !== 4'd9) begin errors++; $display("FAIL mid_setup_pc got=%0d exp=9", pc_out); end
      reset_n = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%0b exp=0", instr_valid); end
      checks++; if (pc_out !== 4'd0) begin errors++; $display("FAIL mid_rst_pc got=%0d exp=0", pc_out); end
      checks++; if (instr_out !== 12'h000) begin errors++; $display("FAIL mid_rst_instr got=%0h exp=0", instr_out); end
      checks++; if (read_address !== 4'd0) begin errors++; $display("FAIL mid_rst_raddr got=%0d exp=0", read_address); end
      #1;
      reset_n = 1'b1;
      step();
      step();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_idle_valid got=%0b exp=0", instr_valid); end
      checks++; if (pc_out !== 4'd0) begin errors++; $display("FAIL mid_idle_pc got=%0d exp=0", pc_out); end
   endtask

   task automatic test_halt();
      mem[4] = 12'hF00;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (pc_out !== 4'd0 || instr_out !== 12'h100) begin errors++; $display("FAIL restart got pc=%0d instr=%0h exp pc=0 instr=100", pc_out, instr_out); end
      for (int i = 0; i < 4; i++) step();
      checks++; if (pc_out !== 4'd4 || instr_valid !== 1'b1) begin errors++; $display("FAIL halt_op_pc got pc=%0d v=%0b exp pc=4 v=1", pc_out, instr_valid); end
      checks++; if (instr_out !== 12'hF00) begin errors++; $display("FAIL halt_op_instr got=%0h exp=f00", instr_out); end
      step();
`ifdef FETCH_HALT_EN
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted got=%0b exp=1", halted); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got=%0b exp=0", instr_valid); end
      checks++; if (instr_out !== 12'h000) begin errors++; $display("FAIL halt_instr got=%0h exp=0", instr_out); end
      start = 1'b1; branch_taken = 1'b1; branch_target = 4'd2;
      #1;
      checks++; if (read_address !== 4'd5) begin errors++; $display("FAIL halt_raddr got=%0d exp=5", read_address); end
      step();
      step();
      checks++; if (pc_out !== 4'd4) begin errors++; $display("FAIL halt_frozen_pc got=%0d exp=4", pc_out); end
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_hold got h=%0b v=%0b exp h=1 v=0", halted, instr_valid); end
      start = 1'b0; branch_taken = 1'b0;
`else
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halted got=%0b exp=0", halted); end
      checks++; if (pc_out !== 4'd5 || instr_valid !== 1'b1) begin errors++; $display("FAIL no_halt_pc got pc=%0d v=%0b exp pc=5 v=1", pc_out, instr_valid); end
      checks++; if (instr_out !== 12'h105) begin errors++; $display("FAIL no_halt_instr got=%0h exp=105", instr_out); end
`endif
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 12'(12'h100 + i);
      test_reset();
      test_start();
      test_stall();
      test_branch(1'b0);
      test_branch(1'b1);
      test_wrap();
      test_reset_mid_run();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the instruction memory.
- Drives the memory's 4-bit read address and absorbs its 1-cycle registered read latency.
- Pairs each returned 12-bit instruction with its PC and a valid flag for the decoder.
- Supports start-from-idle, downstream stall, and zero-bubble branch redirect.

Parameters:
- ADDR_W, 4, PC / read-address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 12, instruction width.
- RESET_PC, 0, PC value after reset.
- HALT_OP, 4'hF, opcode in instruction[INSTR_W-1 -: 4] that halts fetch (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE and begins fetching at RESET_PC.
- stall  in  1  downstream cannot accept; hold the current instruction.
- branch_taken  in  1  redirect fetch to branch_target this cycle.
- branch_target  in  ADDR_W  redirect address.
- read_address  out  ADDR_W  address to the instruction memory (combinational).
- instruction_in  in  INSTR_W  memory data; reflects the address presented in the previous cycle.
- instr_out  out  INSTR_W  instruction to the decoder.
- pc_out  out  ADDR_W  PC of instr_out.
- instr_valid  out  1  instr_out/pc_out are valid.
- halted  out  1  fetch stopped on HALT_OP.

Behaviour:
- Registers:
  - pc: next address to fetch.
  - pc_q: address of the in-flight instruction.
  - valid_q.
  - state: IDLE, RUN, HALT.
- Reset (reset_n low, asynchronous): pc=RESET_PC, pc_q=RESET_PC, valid_q=0, state=IDLE, halted=0.
  - Outputs during reset: instr_valid=0, instr_out=0, pc_out=RESET_PC, read_address=RESET_PC.
  - Reset asserted mid-operation discards in-flight state immediately.
- read_address:
  - branch_taken in RUN: branch_target.
  - Else stall in RUN: pc_q. Re-reading keeps instruction_in stable across the stall.
  - Otherwise: pc.
- Outputs:
  - instr_valid = valid_q.
  - instr_out = valid_q ? instruction_in : 0.
  - pc_out = pc_q.
- IDLE:
  - Outputs invalid; branch_taken and stall are ignored.
  - start=1 at an edge: state->RUN, valid_q<=1, pc_q<=pc, pc<=pc+1.
  - The instruction at RESET_PC is therefore valid in the first cycle after start is sampled.
- RUN, priority branch > stall > advance:
  - branch_taken: pc_q<=branch_target, pc<=branch_target+1, valid_q<=1. Zero bubbles: the target instruction is valid next cycle. Branch overrides a simultaneous stall.
  - stall: pc, pc_q, valid_q held; instr_valid stays 1 with an unchanged instr_out/pc_out.
  - Otherwise: pc_q<=pc, pc<=pc+1.
- Wrap-around: the (2^ADDR_W - 1) + 1 increment yields 0, with no flag. branch_target = 2^ADDR_W - 1 gives pc = 0.
- start is ignored outside IDLE. The only exit from RUN/HALT back to IDLE is reset.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - In RUN, with valid_q=1, stall=0, branch_taken=0 and instruction_in opcode == HALT_OP at an edge: state->HALT, valid_q<=0, halted<=1.
  - The halt instruction itself is presented with instr_valid=1 for that one cycle.
  - In HALT: pc/pc_q frozen, instr_valid=0, read_address=pc, and all inputs except reset are ignored.
  - A stalled or branched-over HALT_OP does not halt.
- Undefined:
  - No HALT state; HALT_OP is treated as an ordinary instruction.
  - halted is tied to 0.

Test Plan:
- Reset then start=1 for one cycle, memory[i]=12'h100+i -> cycle+1: instr_valid=1, pc_out=0, instr_out=12'h100; then pc_out 1,2,3 with matching data on consecutive cycles.
- Stall held 3 cycles while pc_out=5 -> read_address=5, instr_out=12'h105, pc_out=5, instr_valid=1 for all 3 cycles; after release pc_out=6 with 12'h106 on the next cycle.
- branch_taken=1, branch_target=12 while pc_out=3 -> read_address=12 that cycle; next cycle pc_out=12, instr_out=12'h10C; then 13. Repeat with stall=1 simultaneously -> same result.
- Run from pc_out=14 -> sequence 14, 15, 0, 1; read_address wraps 15->0 with no glitch in instr_valid.
- reset_n pulsed low mid-run at pc_out=9 -> outputs return to reset values asynchronously; state IDLE; no fetch until the next start.
- FETCH_HALT_EN defined, memory[4]=12'hF00 -> pc_out=4 valid for one cycle, then halted=1, instr_valid=0, pc frozen despite start/branch. Macro undefined -> fetch continues to pc_out=5.
